// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/load-store memory port arbiter.
// Optional round-robin tie-break is enabled with ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_D) ? OWN_I : OWN_D;
  endfunction

endpackage

// File: rtl/arb_pick2.sv
// Combinational two-way pick between fetch and data requests.
// ARB_ROUND_ROBIN_EN selects alternating tie-break; otherwise data wins ties.
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_t last_grant,
  output owner_t owner
);

  // Tie-break only matters when both sides request together
  always_comb begin
    owner = OWN_D;
    if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      owner = other_owner(last_grant);
`else
      owner = OWN_D;
`endif
    end else if (i_req) begin
      owner = OWN_I;
    end else begin
      owner = OWN_D;
    end
  end

`ifndef ARB_ROUND_ROBIN_EN
  logic unused_last_grant_s;
  assign unused_last_grant_s = last_grant;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (read-only) and load/store.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default is data priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  owner_t            pick_s, last_grant_s;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

`ifdef ARB_ROUND_ROBIN_EN
  owner_t last_grant_q, last_grant_d;
  assign last_grant_s = last_grant_q;
`else
  assign last_grant_s = OWN_D;
`endif

  arb_pick2 u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant_s),
    .owner      (pick_s)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          owner_d   = pick_s;
          mem_req_d = 1'b1;
          state_d   = ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d = pick_s;
`endif
          if (pick_s == OWN_D) begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = i_addr;
            mem_wdata_d = {DATA_W{1'b0}};
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        // mem_ready only counts here, where mem_req is known to be high
        if (mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = DONE;
          if (owner_q == OWN_I) begin
            i_rdata_d = mem_rdata;
            i_ready_d = 1'b1;
          end else begin
            d_ready_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end else begin
              d_rdata_d = d_rdata_q;
            end
          end
        end else begin
          state_d = ACCESS;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_D;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      i_rdata_q   <= {DATA_W{1'b0}};
      d_rdata_q   <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Last-grant register; reset to data so the first tie goes to fetch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= OWN_D;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port instruction/data memory between the fetch stage (read-only) and the load/store stage (read/write). Sits between the CPU core and the memory macro. Accepts level-held requests from both sides, grants one at a time, and drives the memory's req/ready handshake. It returns read data with a one-cycle ready pulse to the owning requester.

## Interface
- ADDR_W, 32, byte address width on all ports
- DATA_W, 32, data width on all ports
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low; 0 clears all state
- i_req  input  1  fetch request, level, held until i_ready
- i_addr  input  ADDR_W  fetch address
- i_ready  output  1  one-cycle pulse: fetch complete, i_rdata valid
- i_rdata  output  DATA_W  last fetched word
- d_req  input  1  data request, level, held until d_ready
- d_we  input  1  1 = write, 0 = read
- d_addr  input  ADDR_W  data address
- d_wdata  input  DATA_W  write data
- d_ready  output  1  one-cycle pulse: data access complete
- d_rdata  output  DATA_W  last data-read word
- mem_req  output  1  memory access strobe, held until mem_ready
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_ready  input  1  memory done; mem_rdata valid this cycle
- mem_rdata  input  DATA_W  memory read data
- busy  output  1  state is not IDLE

## Operation
- FSM states: IDLE, ACCESS, DONE. The owner register holds I or D.
- IDLE:
  - If no request is present, stay in IDLE.
  - Otherwise pick an owner and register mem_addr, mem_we and mem_wdata from that owner's inputs. Set mem_req=1 and go to ACCESS.
  - A fetch always drives mem_we=0 and mem_wdata=0.
- ACCESS:
  - Hold all mem_* outputs stable.
  - On mem_ready=1: capture mem_rdata into i_rdata (owner I) or into d_rdata (owner D, read only). Drop mem_req and go to DONE.
- DONE: pulse the owner's ready for exactly one cycle, then go to IDLE.
- Writes leave d_rdata unchanged. i_rdata and d_rdata hold their value until the next capture.
- Requesters sample ready at the clock edge and drop or refresh req after it. A req still high in IDLE after DONE is a new request.
- Arbitration when both requests are present in IDLE: see Configuration. When only one request is present, it is granted.
- A requester that drops req during ACCESS is a protocol violation. The access still completes and ready still pulses.
- Reset mid-access aborts the access. No ready pulse is issued and mem_req drops immediately (asynchronous).
- The memory must not assert mem_ready while mem_req=0. If it does, the arbiter ignores it.

## Timing
- Reset values: i_ready, d_ready, mem_req, mem_we, busy = 0. i_rdata, d_rdata, mem_addr, mem_wdata = 0. State = IDLE. last_grant = D.
- Cycle 0: req seen in IDLE. Cycle 1: mem_req=1. Cycle k≥1: mem_ready. Cycle k+1: x_ready=1. Cycle k+2: IDLE again.
- Minimum latency from req to ready is 2 cycles (mem_ready in cycle 1). Maximum throughput is one access per 3 cycles.
- There is no timeout. mem_req is held indefinitely until mem_ready.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - On a tie, grant the requester that was not granted last.
  - last_grant updates on every grant.
  - Reset value D means the first tie goes to I.
- ARB_ROUND_ROBIN_EN undefined:
  - On a tie, D always wins (fixed priority).
  - last_grant is not implemented.
  - Fetch can starve under continuous data traffic; this is accepted.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE/ACCESS/DONE)
  - the owner encoding (OWN_I=0, OWN_D=1)
  - the ADDR_W/DATA_W defaults
- One sub-module, arb_pick2: combinational 2-way pick. Inputs are i_req, d_req and last_grant; output is the owner. Its round-robin path is gated by ARB_ROUND_ROBIN_EN.

## Test plan
- Reset, then assert and release: all outputs 0, busy=0. Pull reset low during ACCESS: mem_req drops asynchronously and no ready pulse follows.
- Single fetch: i_addr=0x0000_0010, mem_rdata=0x0000_0013 with mem_ready in the first ACCESS cycle. Expect:
  - mem_addr=0x10 and mem_we=0 in cycle 1
  - i_ready=1 with i_rdata=0x13 in cycle 2
  - busy low in cycle 3
- Data write then read at 0x100 with d_wdata=0xDEADBEEF and memory delaying mem_ready by 4 cycles. Expect:
  - mem_req held 4 cycles with stable mem_* outputs
  - d_rdata unchanged after the write; d_rdata=0xDEADBEEF after the read
- Simultaneous continuous i_req and d_req, 6 accesses:
  - with ARB_ROUND_ROBIN_EN, grants are I,D,I,D,I,D
  - without it, grants are D,D,D,D,D,D
- Spurious mem_ready=1 in IDLE: no state change and no ready pulse. Requester drops req mid-ACCESS: the access completes and the ready pulse is still issued.
